imem_boot_sequencer: RTL

Loads a program into the multicycle CPU's instruction memory from a host word stream, then releases the CPU and launches it. It drives the memory's external write port (I_MEM_Write_Enable/Data_In/Write_Addr) and the datapath's reset and start inputs. It holds the CPU in reset throughout every load, so the memory port is never shared with a running datapath.

---
 rtl/imem_boot_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer
//   Loads a program from a host word stream into the instruction memory's
//   external write port, holds the CPU in reset during the load and for
//   RST_HOLD cycles after it, then pulses cpu_start and lets the CPU run.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   load_req, load_len  load request and word count (sampled in IDLE/RUN)
//   s_valid, s_data     host word stream
//   s_ready             word accepted this cycle when s_valid is high
//   I_MEM_*             instruction-memory write port (1-cycle latency)
//   cpu_rst, cpu_start  datapath reset (active high) and start pulse
//   busy, done          LOAD/HOLD/START and RUN indicators
//   err_len             pulse on a zero-length load request
//   words_loaded        words written in the current or last load
module imem_boot_sequencer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RST_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              I_MEM_Write_Enable,
  output logic [DATA_W-1:0] I_MEM_Data_In,
  output logic [ADDR_W-1:0] I_MEM_Write_Addr,
  output logic              cpu_rst,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StStart, StRun} state_e;

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
  // Hold counter counts down to zero; the final-write cycle is the first hold cycle.
  localparam logic [7:0]        HoldInit  = 8'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              s_ready_q, s_ready_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              cpu_start_q, cpu_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_len_q, err_len_d;

  logic              handshake;
  logic [ADDR_W-1:0] cnt_inc;

  assign handshake = s_valid & s_ready_q;
  assign cnt_inc   = cnt_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    err_len_d = 1'b0;

    unique case (state_q)
      StIdle, StRun: begin
        if (load_req) begin
          if (load_len != '0) begin
            len_d   = load_len;
            cnt_d   = '0;
            state_d = StLoad;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (handshake) begin
          we_d   = 1'b1;
          data_d = s_data;
          addr_d = StartAddr + cnt_q;  // wraps modulo 2^ADDR_W
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StHold;
            hold_d  = HoldInit;
          end
        end
      end
      StHold: begin
        if (hold_q == 8'd0) begin
          state_d = StStart;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      StStart: state_d = StRun;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    s_ready_d   = (state_d == StLoad);
    cpu_rst_d   = !((state_d == StStart) || (state_d == StRun));
    cpu_start_d = (state_d == StStart);
    busy_d      = (state_d == StLoad) || (state_d == StHold) || (state_d == StStart);
    done_d      = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      s_ready_q   <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      cpu_rst_q   <= 1'b1;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      s_ready_q   <= s_ready_d;
      we_q        <= we_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_start_q <= cpu_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
    end
  end

  assign s_ready            = s_ready_q;
  assign I_MEM_Write_Enable = we_q;
  assign I_MEM_Data_In      = data_q;
  assign I_MEM_Write_Addr   = addr_q;
  assign cpu_rst            = cpu_rst_q;
  assign cpu_start          = cpu_start_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_len            = err_len_q;
  assign words_loaded       = cnt_q;

endmodule
